// File: rtl/contador_9b.sv
// contador_9b - synchronous event counter with terminal-count flag.
//
// Counts the clock cycles in which `add` is high and raises `s` when the
// internal count reaches TERMINAL. The controller uses it as a timeout or
// attempt counter: it holds `add` high and waits for `s`.
//
// Parameters
//   WIDTH    counter width in bits (top level uses 9)
//   TERMINAL count value that raises s; must fit in WIDTH bits
//
// Ports
//   clk    in   rising-edge clock, the only clock
//   reset  in   synchronous active-high reset, wins over add
//   add    in   count enable, one increment per edge while high
//   s      out  terminal-count flag, decoded from the count register only
//
// Build option
//   CONTADOR_9B_WRAP_EN undefined: the counter saturates at TERMINAL and s
//                                  stays high until reset.
//   CONTADOR_9B_WRAP_EN defined:   a counted edge at TERMINAL wraps the count
//                                  to 0, so s pulses once per TERMINAL+1
//                                  counted edges.

module contador_9b #(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned TERMINAL = 511
) (
    input  logic clk,
    input  logic reset,
    input  logic add,
    output logic s
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt;
    logic             at_term;

    assign at_term = (cnt == TERM_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (add) begin
            if (at_term) begin
`ifdef CONTADOR_9B_WRAP_EN
                cnt <= '0;
`else
                cnt <= cnt;
`endif
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    // Decoded from the register only, so add and reset never reach s
    // combinationally.
    assign s = at_term;

endmodule

// File: tb/tb_contador_9b.sv
// tb_contador_9b - directed self-checking bench for contador_9b.
//
// Covers the default build; define CONTADOR_9B_WRAP_EN for the wrap build.

module tb_contador_9b;

    logic clk;
    logic reset;
    logic add;
    logic s;

    int unsigned n_checks;
    int unsigned n_errors;

    contador_9b #(
        .WIDTH   (9),
        .TERMINAL(511)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .add  (add),
        .s    (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle 1 ns so sampling and driving are away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned k);
        for (int unsigned i = 0; i < k; i++) tick();
    endtask

    // Edges with add=1 until s goes high, bounded.
    task automatic edges_to_s(input int unsigned bound, output int unsigned n);
        n = 0;
        while (!s && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset(input int unsigned k);
        reset = 1'b1;
        add   = 1'b0;
        ticks(k);
        reset = 1'b0;
    endtask

    int unsigned n;
    int unsigned highs;
    int unsigned stuck_low;
    int unsigned pos [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        add      = 1'b0;
        #1;

        // Reset
        ticks(2);
        check("reset_s", 32'(s), 0);
        check("reset_cnt", 32'(dut.cnt), 0);

`ifndef CONTADOR_9B_WRAP_EN
        // Count to terminal from reset release
        reset = 1'b0;
        add   = 1'b1;
        tick();
        check("s_after_1", 32'(s), 0);
        ticks(509);
        check("s_after_510", 32'(s), 0);
        tick();
        check("s_after_511", 32'(s), 1);
        check("cnt_at_term", 32'(dut.cnt), 511);

        // Saturation: s stays high while add continues
        stuck_low = 0;
        for (int unsigned i = 0; i < 500; i++) begin
            tick();
            if (!s) stuck_low++;
        end
        check("sat_s_low_cycles", stuck_low, 0);
        check("sat_cnt", 32'(dut.cnt), 511);

        // Hold at terminal with add=0
        add = 1'b0;
        ticks(3);
        check("term_hold_s", 32'(s), 1);

        // Reset with add high clears the sticky flag
        add   = 1'b1;
        reset = 1'b1;
        tick();
        check("sat_clear_s", 32'(s), 0);
        check("sat_clear_cnt", 32'(dut.cnt), 0);

        // Hold mid-count
        reset = 1'b0;
        add   = 1'b1;
        ticks(100);
        check("hold_pre_cnt", 32'(dut.cnt), 100);
        add = 1'b0;
        ticks(50);
        check("hold_cnt", 32'(dut.cnt), 100);
        check("hold_s", 32'(s), 0);
        add = 1'b1;
        edges_to_s(1000, n);
        check("hold_rise_edges", n, 411);

        // Priority: reset beats add at cnt=300
        do_reset(1);
        add = 1'b1;
        ticks(300);
        check("prio_pre_cnt", 32'(dut.cnt), 300);
        reset = 1'b1;
        tick();
        check("prio_s", 32'(s), 0);
        check("prio_cnt", 32'(dut.cnt), 0);
        reset = 1'b0;
        ticks(5);
        check("prio_resume_cnt", 32'(dut.cnt), 5);
        edges_to_s(1000, n);
        check("prio_rise_edges", n, 506);
`else
        // Wrap: s high on counted edges 511, 1023, 1535, one cycle each
        reset = 1'b0;
        add   = 1'b1;
        highs = 0;
        for (int unsigned i = 1; i <= 1600; i++) begin
            tick();
            if (s) begin
                if (highs < 4) pos[highs] = i;
                highs++;
            end
        end
        check("wrap_high_cycles", highs, 3);
        check("wrap_pos0", pos[0], 511);
        check("wrap_pos1", pos[1], 1023);
        check("wrap_pos2", pos[2], 1535);

        // add=0 at terminal holds; next counted edge wraps to 0
        do_reset(1);
        add = 1'b1;
        ticks(510);
        check("wrap_s_510", 32'(s), 0);
        tick();
        check("wrap_s_511", 32'(s), 1);
        add = 1'b0;
        ticks(3);
        check("wrap_hold_s", 32'(s), 1);
        check("wrap_hold_cnt", 32'(dut.cnt), 511);
        add = 1'b1;
        tick();
        check("wrap_edge_s", 32'(s), 0);
        check("wrap_edge_cnt", 32'(dut.cnt), 0);

        // Priority unchanged in wrap build
        ticks(300);
        check("prio_pre_cnt", 32'(dut.cnt), 300);
        reset = 1'b1;
        tick();
        check("prio_s", 32'(s), 0);
        check("prio_cnt", 32'(dut.cnt), 0);
        reset = 1'b0;
        edges_to_s(1000, n);
        check("prio_rise_edges", n, 511);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
